// File: rtl/gobang_win_checker_if.sv
// gobang_win_checker_if: signal bundle between the GoBang control side and
// the win checker.
//   master : move request (start, mv_x, mv_y, mv_player), board read data
//            (rd_data); observes the read strobe and address plus the status
//            outputs (busy, done, win, winner, win_dir).
//   slave  : the win checker itself, with the opposite directions.
// Parameter COORD_W must match the checker's COORD_W.
interface gobang_win_checker_if #(
  parameter int COORD_W = 4
);
  logic               start;
  logic [COORD_W-1:0] mv_x;
  logic [COORD_W-1:0] mv_y;
  logic               mv_player;
  logic               rd_en;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  logic [1:0]         rd_data;
  logic               busy;
  logic               done;
  logic               win;
  logic               winner;
  logic [1:0]         win_dir;

  modport master (
    output start, mv_x, mv_y, mv_player, rd_data,
    input  rd_en, rd_x, rd_y, busy, done, win, winner, win_dir
  );

  modport slave (
    input  start, mv_x, mv_y, mv_player, rd_data,
    output rd_en, rd_x, rd_y, busy, done, win, winner, win_dir
  );
endinterface

// File: rtl/gobang_win_checker.sv
// gobang_win_checker: after each accepted move, reads the board back along
// the four lines through the new stone (horizontal, vertical, diagonal,
// anti-diagonal; each walked on the + side then the - side) and reports
// whether the mover owns a winning run.
// Ports:
//   clock   : system clock
//   resetn  : asynchronous active-low reset
//   bus     : gobang_win_checker_if.slave
//             start/mv_x/mv_y/mv_player  move to check (start is a pulse)
//             rd_en/rd_x/rd_y/rd_data    board read port, data one cycle late
//             busy/done                  check in progress / finished pulse
//             win/winner/win_dir         result of the last completed check
// Build option: define GOBANG_EXACT_FIVE_EN for the exact-five rule (probe one
// cell past the run on each side; only a run of exactly WIN_LEN wins).
module gobang_win_checker #(
  parameter int BOARD_N = 15,
  parameter int COORD_W = 4,
  parameter int WIN_LEN = 5
) (
  input  logic               clock,
  input  logic               resetn,
  gobang_win_checker_if.slave bus
);

`ifdef GOBANG_EXACT_FIVE_EN
  localparam int MAXSTEP = WIN_LEN;
`else
  localparam int MAXSTEP = WIN_LEN - 1;
`endif
  localparam int AW     = COORD_W + 1;
  localparam int STEP_W = $clog2(MAXSTEP + 2);
  localparam int CNT_W  = $clog2(2 * MAXSTEP + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_READ,
    S_CMP,
    S_DONE
  } state_t;

  state_t              state;
  logic [COORD_W-1:0]  cx_q, cy_q;
  logic                player_q;
  logic [1:0]          dir_q;
  logic                side_q;   // 0 = + side, 1 = - side
  logic [STEP_W-1:0]   step_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                rd_en_q;
  logic [COORD_W-1:0]  rd_x_q, rd_y_q;
  logic                busy_q, done_q, win_q, winner_q;
  logic [1:0]          win_dir_q;

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_x    = rd_x_q;
  assign bus.rd_y    = rd_y_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.win     = win_q;
  assign bus.winner  = winner_q;
  assign bus.win_dir = win_dir_q;

  function automatic logic win_rule(input logic [CNT_W-1:0] c);
`ifdef GOBANG_EXACT_FIVE_EN
    return int'(c) == WIN_LEN;
`else
    return int'(c) >= WIN_LEN;
`endif
  endfunction

  logic [1:0] stone;
  assign stone = player_q ? 2'b10 : 2'b01;

  logic move_oob;
  assign move_oob = (AW'(bus.mv_x) >= AW'(BOARD_N)) || (AW'(bus.mv_y) >= AW'(BOARD_N));

  // Walk seed: in SETUP the registered position; in CMP the position after
  // applying the compare result. A miss forces step past MAXSTEP so the walker
  // below treats it exactly like running out of steps.
  logic [1:0]        seed_dir;
  logic              seed_side;
  logic [STEP_W-1:0] seed_step;
  logic [CNT_W-1:0]  seed_cnt;

  always_comb begin
    seed_dir  = dir_q;
    seed_side = side_q;
    seed_step = step_q;
    seed_cnt  = cnt_q;
    if (state == S_CMP) begin
      if (bus.rd_data == stone) begin
        seed_step = step_q + STEP_W'(1);
        seed_cnt  = cnt_q + CNT_W'(1);
      end else begin
        seed_step = STEP_W'(MAXSTEP + 1);
      end
    end
  end

  // Side switches and direction evaluations are resolved in the same cycle
  // until either an on-board cell to read is found or the check ends. Eight
  // passes cover the longest chain (every remaining side of every direction
  // failing), so each probe costs only the READ and CMP cycles.
  logic [1:0]         w_dir;
  logic               w_side;
  logic [STEP_W-1:0]  w_step;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_found, w_end, w_win;
  logic [COORD_W-1:0] w_x, w_y;
  logic [AW-1:0]      px, py, off;

  always_comb begin
    w_dir   = seed_dir;
    w_side  = seed_side;
    w_step  = seed_step;
    w_cnt   = seed_cnt;
    w_found = 1'b0;
    w_end   = 1'b0;
    w_win   = 1'b0;
    w_x     = '0;
    w_y     = '0;
    px      = '0;
    py      = '0;
    off     = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (!w_found && !w_end) begin
        off = AW'(w_step);
        px  = AW'(cx_q);
        py  = AW'(cy_q);
        if (w_dir != 2'd0)
          px = w_side ? px - off : px + off;
        case (w_dir)
          2'd0, 2'd2: py = w_side ? py - off : py + off;
          2'd3:       py = w_side ? py + off : py - off;
          default:    ;
        endcase
        // Underflow wraps to a large value, so one unsigned compare per axis
        // catches both edges.
        if ((int'(w_step) <= MAXSTEP) && (px < AW'(BOARD_N)) && (py < AW'(BOARD_N))) begin
          w_found = 1'b1;
          w_x     = px[COORD_W-1:0];
          w_y     = py[COORD_W-1:0];
        end else if (!w_side) begin
          w_side = 1'b1;
          w_step = STEP_W'(1);
        end else if (win_rule(w_cnt)) begin
          w_end = 1'b1;
          w_win = 1'b1;
        end else if (w_dir == 2'd3) begin
          w_end = 1'b1;
        end else begin
          w_dir  = w_dir + 2'd1;
          w_side = 1'b0;
          w_step = STEP_W'(1);
          w_cnt  = CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cx_q      <= '0;
      cy_q      <= '0;
      player_q  <= 1'b0;
      dir_q     <= '0;
      side_q    <= 1'b0;
      step_q    <= '0;
      cnt_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      win_q     <= 1'b0;
      winner_q  <= 1'b0;
      win_dir_q <= '0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            cx_q      <= bus.mv_x;
            cy_q      <= bus.mv_y;
            player_q  <= bus.mv_player;
            win_q     <= 1'b0;
            winner_q  <= 1'b0;
            win_dir_q <= '0;
            dir_q     <= '0;
            side_q    <= 1'b0;
            step_q    <= STEP_W'(1);
            cnt_q     <= CNT_W'(1);
            if (move_oob) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              state  <= S_SETUP;
              busy_q <= 1'b1;
            end
          end
        end
        S_SETUP, S_CMP: begin
          dir_q  <= w_dir;
          side_q <= w_side;
          step_q <= w_step;
          cnt_q  <= w_cnt;
          if (w_found) begin
            state   <= S_READ;
            rd_en_q <= 1'b1;
            rd_x_q  <= w_x;
            rd_y_q  <= w_y;
          end else begin
            state  <= S_DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            if (w_win) begin
              win_q     <= 1'b1;
              winner_q  <= player_q;
              win_dir_q <= w_dir;
            end
          end
        end
        S_READ:  state <= S_CMP;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gobang_win_checker.sv
// tb_gobang_win_checker: directed bench for gobang_win_checker. Holds a
// 15x15 board model answering the read port one cycle after rd_en, logs every
// read, and checks results, read sequences and timing against hand-computed
// values. Expectations that differ under GOBANG_EXACT_FIVE_EN are selected
// with the same macro.
module tb_gobang_win_checker;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  gobang_win_checker_if #(.COORD_W(4)) bus ();

  gobang_win_checker #(
    .BOARD_N(15),
    .COORD_W(4),
    .WIN_LEN(5)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] board [15][15];
  logic [7:0] rd_log [80];
  int n_reads = 0;
  int n_bad   = 0;
  int done_cnt = 0;

  always @(posedge clock) begin
    if (bus.rd_en) begin
      if (bus.rd_x < 4'd15 && bus.rd_y < 4'd15)
        bus.rd_data <= board[bus.rd_x][bus.rd_y];
      else begin
        bus.rd_data <= 2'b00;
        n_bad++;
      end
      if (n_reads < 80) rd_log[n_reads] = {bus.rd_x, bus.rd_y};
      n_reads++;
    end
  end

  always @(negedge clock) if (bus.done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {bus.rd_en, bus.rd_x, bus.rd_y, bus.busy, bus.done, bus.win, bus.winner, bus.win_dir};
  endfunction

  task automatic clear_board();
    for (int i = 0; i < 15; i++)
      for (int j = 0; j < 15; j++)
        board[i][j] = 2'b00;
  endtask

  task automatic issue(input logic [3:0] x, input logic [3:0] y, input logic p);
    @(negedge clock);
    n_reads = 0;
    n_bad   = 0;
    bus.mv_x      = x;
    bus.mv_y      = y;
    bus.mv_player = p;
    bus.start     = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
  endtask

  // Counts negedges after the accepting edge; the first one is cycle 1.
  task automatic wait_done(input int cyc0, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = cyc0;
    while (!seen && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (bus.done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 0, 1);
    else begin
      check("busy_at_done", bus.busy, 0);
      @(negedge clock);
      check("done_pulse_width", bus.done, 0);
    end
  endtask

  logic [7:0] exp_rd [8];
  int cyc;
  int dc;

  initial begin
    bus.start = 1'b0;
    bus.mv_x = '0;
    bus.mv_y = '0;
    bus.mv_player = 1'b0;
    clear_board();
    exp_rd[0] = 8'h78; exp_rd[1] = 8'h76; exp_rd[2] = 8'h87; exp_rd[3] = 8'h67;
    exp_rd[4] = 8'h88; exp_rd[5] = 8'h66; exp_rd[6] = 8'h86; exp_rd[7] = 8'h68;

    #22;
    check("reset_outputs", 32'(outs()), 0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("idle_outputs", 32'(outs()), 0);

    // Empty board, centre move: one read to each neighbour, 18 cycles.
    issue(4'd7, 4'd7, 1'b0);
    wait_done(0, cyc);
    check("t1_cycles", cyc, 18);
    check("t1_reads", n_reads, 8);
    for (int i = 0; i < 8; i++) check($sformatf("t1_read%0d", i), rd_log[i], exp_rd[i]);
    check("t1_win", bus.win, 0);

    // Horizontal run of player0 ending at the move.
    for (int j = 3; j <= 6; j++) board[7][j] = 2'b01;
    issue(4'd7, 4'd7, 1'b0);
    wait_done(0, cyc);
    check("t2_win", bus.win, 1);
    check("t2_winner", bus.winner, 0);
    check("t2_dir", bus.win_dir, 0);
`ifdef GOBANG_EXACT_FIVE_EN
    check("t2_reads", n_reads, 6);
`else
    check("t2_reads", n_reads, 5);
`endif
    for (int i = 0; i < n_reads && i < 80; i++) check($sformatf("t2_row%0d", i), 32'(rd_log[i][7:4]), 7);
    repeat (5) @(negedge clock);
    check("t2_win_held", bus.win, 1);

    // Player1 diagonal from the top-left edge; result cleared on accept.
    clear_board();
    board[0][1] = 2'b10; board[1][2] = 2'b10; board[2][3] = 2'b10; board[3][4] = 2'b10;
    board[5][6] = 2'b11;
    issue(4'd4, 4'd5, 1'b1);
    @(negedge clock);
    check("t3_win_cleared", bus.win, 0);
    check("t3_busy", bus.busy, 1);
    wait_done(1, cyc);
    check("t3_win", bus.win, 1);
    check("t3_winner", bus.winner, 1);
    check("t3_dir", bus.win_dir, 2);
    check("t3_reads", n_reads, 9);
    check("t3_bad_reads", n_bad, 0);

    // Run belongs to the other player.
    clear_board();
    for (int i = 2; i <= 5; i++) board[i][0] = 2'b01;
    issue(4'd6, 4'd0, 1'b1);
    wait_done(0, cyc);
    check("t4_win", bus.win, 0);
    check("t4_reads", n_reads, 5);
    check("t4_bad_reads", n_bad, 0);

    // Corner move.
    clear_board();
    issue(4'd0, 4'd0, 1'b0);
    wait_done(0, cyc);
    check("t5_cycles", cyc, 8);
    check("t5_reads", n_reads, 3);
    check("t5_bad_reads", n_bad, 0);
    check("t5_win", bus.win, 0);

    // Out-of-range move.
    issue(4'd15, 4'd3, 1'b0);
    wait_done(0, cyc);
    check("t6_cycles", cyc, 1);
    check("t6_reads", n_reads, 0);
    check("t6_win", bus.win, 0);

    // Six in a row.
    for (int j = 2; j <= 6; j++) board[7][j] = 2'b01;
    issue(4'd7, 4'd7, 1'b0);
    wait_done(0, cyc);
`ifdef GOBANG_EXACT_FIVE_EN
    check("t7_win", bus.win, 0);
    check("t7_reads", n_reads, 12);
`else
    check("t7_win", bus.win, 1);
    check("t7_dir", bus.win_dir, 0);
`endif

    // start while busy is ignored.
    clear_board();
    issue(4'd7, 4'd7, 1'b0);
    repeat (3) @(negedge clock);
    bus.mv_x = 4'd15;
    bus.mv_y = 4'd3;
    bus.mv_player = 1'b1;
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    wait_done(3, cyc);
    check("t8_cycles", cyc, 18);
    check("t8_reads", n_reads, 8);
    check("t8_win", bus.win, 0);

    // Reset in the middle of a winning check.
    for (int j = 3; j <= 6; j++) board[7][j] = 2'b01;
    issue(4'd7, 4'd7, 1'b0);
    repeat (6) @(negedge clock);
    dc = done_cnt;
    #2 resetn = 1'b0;
    #1 check("t9_reset_outputs", 32'(outs()), 0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    n_reads = 0;
    repeat (40) @(negedge clock);
    check("t9_no_done", done_cnt, dc);
    check("t9_no_reads", n_reads, 0);
    check("t9_win", bus.win, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
